pic_host_bus_master: RTL and testbench

- CPU-side initiator for the 8259-style PIC bus, one per PIC master.
- Converts single-cycle command requests into timed CS_n/RD_n/WR_n/A0 bus strobes for ICW/OCW writes and status reads (IRR/ISR/mask).
- When INT is asserted, autonomously runs the two-pulse INTA acknowledge sequence and captures the vector byte.
- Sits between the test/CPU model and the PIC's parallel bus and INT/INTA pins.

---
 rtl/pic_bus_pkg.sv | 34 +++
 rtl/pic_pulse_timer.sv | 31 +++
 rtl/pic_host_bus_master.sv | 209 ++++++++++++++++++++
 tb/tb_pic_host_bus_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259-style PIC host bus master.
package pic_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SETUP    = 4'd1,
        ST_STROBE   = 4'd2,
        ST_HOLD     = 4'd3,
        ST_RECOVER  = 4'd4,
        ST_ACK1     = 4'd5,
        ST_ACK_GAP  = 4'd6,
        ST_ACK2     = 4'd7,
        ST_ACK_DONE = 4'd8
    } pic_state_e;

    localparam logic A0_ICW1_OCW23  = 1'b0;
    localparam logic A0_ICW234_OCW1 = 1'b1;

    localparam int unsigned DEF_SETUP_CYC = 32'd1;
    localparam int unsigned DEF_PULSE_CYC = 32'd2;
    localparam int unsigned DEF_GAP_CYC   = 32'd2;
    localparam int unsigned TMR_W         = 32'd8;

    // States in which CS_n is driven low for a register access.
    function automatic logic in_bus_cycle(input pic_state_e s);
        return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

    // The timer counts down to zero, so an N-cycle phase loads N-1.
    function automatic logic [TMR_W-1:0] cyc_to_load(input int unsigned cyc);
        return TMR_W'(cyc - 32'd1);
    endfunction

endpackage

// File: rtl/pic_pulse_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module pic_pulse_timer
    import pic_bus_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Count register: load has priority, otherwise decrement and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for an 8259-style PIC: timed register accesses plus
// autonomous two-pulse INTA acknowledge with vector capture.
module pic_host_bus_master
    import pic_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       int_en,
    input  logic       INT,
    output logic       vec_valid,
    output logic [7:0] vec,
    output logic       busy,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] Dout,
    input  logic [7:0] Din,
    output logic       INTA_n
);

    localparam logic [TMR_W-1:0] LD_SETUP = cyc_to_load(SETUP_CYC);
    localparam logic [TMR_W-1:0] LD_PULSE = cyc_to_load(PULSE_CYC);
    localparam logic [TMR_W-1:0] LD_GAP   = cyc_to_load(GAP_CYC);

    pic_state_e       state_q, state_d;
    logic             wr_q, wr_d;
    logic             a0_q, a0_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             int_req;

    logic             cs_n_q, rd_n_q, wr_n_q, inta_n_q, a0_out_q, busy_q;
    logic             rsp_valid_q, vec_valid_q;
    logic [7:0]       dout_q, rsp_rdata_q, vec_q;

    assign int_req   = int_en && INT;
    // A pending acknowledge blocks new commands so it always wins a tie.
    assign cmd_ready = !rst && (state_q == ST_IDLE) && !int_req;

    pic_pulse_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Next-state, command latch and phase-timer load decisions.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        a0_d     = a0_q;
        wdata_d  = wdata_q;
        tmr_load = 1'b0;
        tmr_val  = LD_PULSE;
        case (state_q)
            ST_IDLE: begin
                if (int_req) begin
                    state_d  = ST_ACK1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PULSE;
                end else if (cmd_valid) begin
                    state_d  = ST_SETUP;
                    wr_d     = cmd_write;
                    a0_d     = cmd_a0 ? A0_ICW234_OCW1 : A0_ICW1_OCW23;
                    wdata_d  = cmd_wdata;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PULSE;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_HOLD: begin
                state_d  = ST_RECOVER;
                tmr_load = 1'b1;
                tmr_val  = LD_GAP;
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            ST_ACK1: begin
                if (tmr_done) begin
                    state_d  = ST_ACK_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end else begin
                    state_d = ST_ACK1;
                end
            end
            ST_ACK_GAP: begin
                if (tmr_done) begin
                    state_d  = ST_ACK2;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PULSE;
                end else begin
                    state_d = ST_ACK_GAP;
                end
            end
            ST_ACK2: begin
                if (tmr_done) begin
                    state_d  = ST_ACK_DONE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end else begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK_DONE: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched command and pin registers; pins are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            a0_q        <= A0_ICW1_OCW23;
            wdata_q     <= 8'h00;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            inta_n_q    <= 1'b1;
            a0_out_q    <= 1'b0;
            dout_q      <= 8'h00;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            vec_valid_q <= 1'b0;
            vec_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            a0_q        <= a0_d;
            wdata_q     <= wdata_d;
            cs_n_q      <= !in_bus_cycle(state_d);
            wr_n_q      <= !((state_d == ST_STROBE) && wr_d);
            rd_n_q      <= !((state_d == ST_STROBE) && !wr_d);
            inta_n_q    <= !((state_d == ST_ACK1) || (state_d == ST_ACK2));
            a0_out_q    <= a0_d;
            dout_q      <= (in_bus_cycle(state_d) && wr_d) ? wdata_d : 8'h00;
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_HOLD) && !wr_d;
            vec_valid_q <= (state_q == ST_ACK2) && (state_d == ST_ACK_DONE);
            if ((state_q == ST_STROBE) && tmr_done && !wr_q) begin
                rsp_rdata_q <= Din;
            end
            if ((state_q == ST_ACK2) && tmr_done) begin
                vec_q <= Din;
            end
        end
    end

    assign CS_n      = cs_n_q;
    assign RD_n      = rd_n_q;
    assign WR_n      = wr_n_q;
    assign INTA_n    = inta_n_q;
    assign A0        = a0_out_q;
    assign Dout      = dout_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign vec_valid = vec_valid_q;
    assign vec       = vec_q;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: table of register accesses plus
// hand-written acknowledge, contention, reset and int_en=0 sequences.
module tb_pic_host_bus_master;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_write, cmd_a0, int_en, INT;
    logic [7:0] cmd_wdata, Din;
    logic       cmd_ready, rsp_valid, vec_valid, busy, CS_n, RD_n, WR_n, A0, INTA_n;
    logic [7:0] rsp_rdata, vec, Dout;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    localparam int unsigned WR_LAT = 3;  // SETUP 1 + PULSE 2
    localparam int unsigned TOTAL  = 6;  // SETUP 1 + PULSE 2 + HOLD 1 + GAP 2

    typedef struct {
        logic        w;
        logic        a0;
        logic [7:0]  wd;
        logic [7:0]  din;
        int unsigned exp_wr_lo;
        int unsigned exp_rd_lo;
        int unsigned exp_rsp;
        logic [7:0]  exp_rdata;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    pic_host_bus_master #(.SETUP_CYC(1), .PULSE_CYC(2), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .int_en(int_en), .INT(INT),
        .vec_valid(vec_valid), .vec(vec), .busy(busy), .CS_n(CS_n), .RD_n(RD_n),
        .WR_n(WR_n), .A0(A0), .Dout(Dout), .Din(Din), .INTA_n(INTA_n)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_cmd(input vec_t v, input string tag);
        int unsigned wr_lo = 0, rd_lo = 0, rsp_n = 0, rise_k = 0, idle_k = 0, bad = 0;
        logic [7:0]  rdat = 8'h00;
        logic        prev_lo = 1'b0, acc = 1'b0, lo;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.w; cmd_a0 = v.a0; cmd_wdata = v.wd; Din = v.din;
        for (int t = 0; t < 50 && !acc; t++) begin
            #1;
            if (cmd_ready) acc = 1'b1;
            else @(negedge clk);
        end
        check($sformatf("%s accept", tag), acc, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            lo = !WR_n || !RD_n;
            if (!WR_n) wr_lo++;
            if (!RD_n) rd_lo++;
            if (lo && (CS_n || A0 != v.a0 || Dout != v.exp_dout)) bad++;
            if (!WR_n && !RD_n) bad++;
            if (!INTA_n) bad++;
            if (k >= 5 && (!CS_n || Dout != 8'h00)) bad++;
            if (rsp_valid) begin rsp_n++; rdat = rsp_rdata; end
            if (prev_lo && !lo && rise_k == 0) rise_k = k;
            prev_lo = lo;
            if (!busy && idle_k == 0) idle_k = k;
        end
        check($sformatf("%s wr_lo", tag), wr_lo, v.exp_wr_lo);
        check($sformatf("%s rd_lo", tag), rd_lo, v.exp_rd_lo);
        check($sformatf("%s rsp_cnt", tag), rsp_n, v.exp_rsp);
        check($sformatf("%s bus_fields", tag), bad, 0);
        check($sformatf("%s strobe_rise_lat", tag), rise_k - 1, WR_LAT);
        check($sformatf("%s total_cycles", tag), idle_k - 1, TOTAL);
        if (v.exp_rsp != 0) check($sformatf("%s rdata", tag), rdat, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned bad, vv_n, vv_k, acc_k, inta_lo, wr_lo, first_wr, early;
        logic [9:0]  pat;
        logic [7:0]  vval;

        tbl[0] = '{1'b1, 1'b0, 8'h1B, 8'h00, 2, 0, 0, 8'h00, 8'h1B};  // ICW1
        tbl[1] = '{1'b1, 1'b1, 8'h75, 8'h00, 2, 0, 0, 8'h00, 8'h75};  // ICW2
        tbl[2] = '{1'b1, 1'b1, 8'h02, 8'h00, 2, 0, 0, 8'h00, 8'h02};  // ICW4
        tbl[3] = '{1'b1, 1'b1, 8'hC2, 8'h00, 2, 0, 0, 8'h00, 8'hC2};  // OCW1
        tbl[4] = '{1'b1, 1'b0, 8'h0A, 8'h00, 2, 0, 0, 8'h00, 8'h0A};  // OCW3
        tbl[5] = '{1'b0, 1'b0, 8'h55, 8'h96, 0, 2, 1, 8'h96, 8'h00};  // IRR read
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'hC2, 0, 2, 1, 8'hC2, 8'h00};  // mask read

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0;
        cmd_wdata = 8'h00; int_en = 1'b0; INT = 1'b0; Din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset strobes", {CS_n, RD_n, WR_n, INTA_n}, 4'hF);
        check("reset A0/Dout", {A0, Dout}, 9'h000);
        check("reset valids/busy", {rsp_valid, vec_valid, busy}, 3'b000);
        check("reset data", {rsp_rdata, vec}, 16'h0000);
        check("reset cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1 check("ready after reset", cmd_ready, 1);

        for (int i = 0; i < 7; i++) do_cmd(tbl[i], $sformatf("vec%0d", i));

        // Acknowledge: vector is presented only just before the last ACK2 edge.
        bad = 0; vv_n = 0; vv_k = 0; vval = 8'h00; pat = 10'h000; early = 0;
        @(negedge clk); Din = 8'hEE; int_en = 1'b1; INT = 1'b1;
        #1 check("ack cmd_ready", cmd_ready, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            pat[k-1] = INTA_n;
            if (!CS_n || !WR_n || !RD_n) bad++;
            if (vec_valid) begin vv_n++; vv_k = k; vval = vec; end
            if (k <= 8 && cmd_ready) early++;
            if (k == 2) INT = 1'b0;
            if (k == 6) Din = 8'h72;
            if (k == 7) Din = 8'hEE;
        end
        check("ack INTA_n pattern", pat, 10'b1111001100);
        check("ack vec_valid count", vv_n, 1);
        check("ack vec_valid cycle", vv_k, 7);
        check("ack vec", vval, 8'h72);
        check("ack bus quiet", bad, 0);
        check("ack ready low", early, 0);

        // Contention: command and INT arrive together.
        bad = 0; vv_k = 0; acc_k = 0; inta_lo = 0; wr_lo = 0; first_wr = 0; early = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_wdata = 8'hC2;
        INT = 1'b1; Din = 8'h72;
        #1 check("cont ready at collision", cmd_ready, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!INTA_n) inta_lo++;
            if (vec_valid) vv_k = k;
            if (!WR_n) begin
                wr_lo++;
                if (first_wr == 0) first_wr = k;
                if (Dout != 8'hC2 || CS_n || !A0) bad++;
            end
            if (!CS_n && !INTA_n) bad++;
            if (acc_k != 0) cmd_valid = 1'b0;
            if (k == 2) INT = 1'b0;
            #1;
            if (cmd_ready && acc_k == 0) begin
                if (k < 9) early++;
                acc_k = k;
            end
        end
        check("cont accept cycle", acc_k, 9);
        check("cont ready early", early, 0);
        check("cont vec_valid cycle", vv_k, 7);
        check("cont inta low cycles", inta_lo, 4);
        check("cont wr low cycles", wr_lo, 2);
        check("cont first wr", first_wr, 11);
        check("cont bus fields", bad, 0);
        int_en = 1'b0;

        // Reset during the write strobe.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_wdata = 8'h75;
        #1 check("rst test accept", cmd_ready, 1);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        check("rst WR_n low before", WR_n, 0);
        rst = 1'b1;
        #1 check("rst cmd_ready low", cmd_ready, 0);
        @(negedge clk);
        check("rst strobes high", {CS_n, RD_n, WR_n, INTA_n}, 4'hF);
        check("rst busy/Dout", {busy, Dout}, 9'h000);
        rst = 1'b0;
        #1 check("rst ready after", cmd_ready, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!CS_n || !WR_n || !RD_n || !INTA_n || rsp_valid || vec_valid || busy) bad++;
        end
        check("rst no further activity", bad, 0);

        // int_en=0: INT held high is ignored, commands still serviced.
        int_en = 1'b0; INT = 1'b1; bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!INTA_n || vec_valid || busy) bad++;
        end
        check("int_en=0 no ack", bad, 0);
        do_cmd(tbl[3], "int_en0 cmd");
        INT = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
